uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 UART transmitter; the draining end of the byte FIFO.
- Pops one byte from the FIFO host side whenever the FIFO is non-empty and the transmitter is idle.
- Serialises the byte LSB-first on txd, at a bit period set by a clock-divider parameter.
- Sits between the FIFO and the board TX pin.

Parameters:
- ClockDivider, 868: clock cycles per bit (100 MHz / 115200). Legal values >= 2.
- StopBits, 1: number of stop bits. Legal values 1 or 2.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clock).
- fByte  in  8  FIFO output byte; valid the cycle after fPop.
- fEmpty  in  1  FIFO empty flag.
- fPop  out  1  FIFO pop strobe.
- txd  out  1  serial line; idles high.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, txd=1, fPop=0, busy=0, bit counter=0, divider counter=0.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - fPop is combinational: (state==IDLE && !fEmpty). It is never high in any other state, so it is high for exactly one cycle per byte.
  - If !fEmpty, next state is LOAD; otherwise stay in IDLE.
- LOAD:
  - The FIFO updated its output on the pop edge, so fByte is valid here.
  - shiftReg <= fByte; divider counter cleared; next state is START.
- START: txd=0 for ClockDivider cycles, then DATA with bitIndex=0.
- DATA:
  - txd=shiftReg[0] for ClockDivider cycles; then shift right and bitIndex++.
  - After bitIndex 7 completes, go to STOP.
- STOP: txd=1 for StopBits*ClockDivider cycles, then IDLE.
- Latency: fEmpty low in IDLE at cycle N gives fPop at N, LOAD at N+1, and txd falling at the N+2 edge.
- Frame length: (10 + StopBits - 1)*ClockDivider cycles (plus parity bit when the option is enabled).
- Back-to-back: the inter-frame gap is exactly 2 extra high cycles (IDLE + LOAD); no pop is issued mid-frame.
- Divider counter:
  - Width $clog2(ClockDivider); counts 0..ClockDivider-1, wraps to 0 on every bit boundary.
  - No drift accumulates across bits.
- fByte is sampled only in LOAD; changes at any other time are ignored.
- Reset mid-frame: txd returns high at once; the byte in flight is lost (it was already popped); no spurious fPop while reset is low.
- txd is registered (glitch-free); busy is derived from the registered state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the 8 data bits) for ClockDivider cycles. Frame gains one bit.
- Undefined: the PARITY state and its XOR logic are absent; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg holds:
  - state enum typedef (IDLE, LOAD, START, DATA, PARITY, STOP);
  - localparam DEFAULT_CLOCK_DIVIDER=868;
  - localparam UART_DATA_BITS=8.
- One sub-module is natural: uart_baud_tick.
  - Contents: parameterised divider counter with clear input and single-cycle tick output at count==ClockDivider-1.
  - Reused later by a receiver.

Test Plan:
- Reset: hold reset=0 with fEmpty=0 -> txd=1, fPop=0, busy=0 throughout; release -> fPop=1 on the first cycle.
- Single byte, ClockDivider=4: FIFO holds 0xA5 -> one fPop pulse, then txd = 0 (start), 1,0,1,0,0,1,0,1, 1 (stop), each 4 cycles (40 cycles); busy drops after the stop bit; no further fPop.
- Back-to-back: FIFO holds 0x00 then 0xFF -> two fPop pulses exactly 42 cycles apart; txd high for exactly 2 cycles between the frames.
- Empty FIFO: fEmpty=1 for 1000 cycles -> fPop never asserted; txd constant 1.
- Reset mid-frame: assert reset during bit 3 of 0x3C -> txd=1 the same cycle; after release, the next byte's frame is clean and starts with a single fPop.
- With UART_TX_PARITY_EN, ClockDivider=4: byte 0x07 -> parity bit 1 after bit 7; frame 44 cycles. Byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART blocks
package uart_pkg;

    localparam int DEFAULT_CLOCK_DIVIDER = 868;
    localparam int UART_DATA_BITS        = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider, one-cycle tick on the last cycle of each bit
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int ClockDivider = DEFAULT_CLOCK_DIVIDER
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(ClockDivider);

    logic [CW-1:0] count;

    assign tick = count == CW'(ClockDivider - 1);

    // count 0..ClockDivider-1, restarting on every bit boundary so no drift builds up
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            count <= '0;
        else
            count <= (clear || tick) ? '0 : count + CW'(1);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter draining a byte FIFO; even parity bit when UART_TX_PARITY_EN is defined
module uart_tx
    import uart_pkg::*;
#(
    parameter int ClockDivider = DEFAULT_CLOCK_DIVIDER,
    parameter int StopBits     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] fByte,
    input  logic       fEmpty,
    output logic       fPop,
    output logic       txd,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(StopBits - 1);

    uart_state_t               state, state_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]                bit_idx, bit_next;
    logic                      tick, clear, txd_next;
`ifdef UART_TX_PARITY_EN
    logic                      parity;
`endif

    assign clear = state == IDLE || state == LOAD;

    uart_baud_tick #(.ClockDivider(ClockDivider)) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // state, datapath and the registered line output advance together
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            txd       <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_next;
            txd       <= txd_next;
        end

`ifdef UART_TX_PARITY_EN
    // even parity of the byte, captured alongside it
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            parity <= 1'b0;
        else if (state == LOAD)
            parity <= ^fByte;
`endif

    // frame sequencing; bit_idx counts data bits, then stop bits
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        bit_next   = bit_idx;
        case (state)
            IDLE:  state_next = fEmpty ? IDLE : LOAD;
            LOAD: begin
                shift_next = fByte;
                bit_next   = '0;
                state_next = START;
            end
            START: state_next = tick ? DATA : START;
            DATA: if (tick) begin
                shift_next = shift_reg >> 1;
                bit_next   = bit_idx + 3'd1;
                if (bit_idx == LAST_BIT) begin
                    bit_next = '0;
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_next = tick ? STOP : PARITY;
`endif
            STOP: if (tick) begin
                bit_next   = bit_idx == LAST_STOP ? 3'd0 : bit_idx + 3'd1;
                state_next = bit_idx == LAST_STOP ? IDLE : STOP;
            end
            default: state_next = IDLE;
        endcase
    end

    // pop strobe, busy and the line level for the coming state
    always_comb begin
        fPop = reset && state == IDLE && !fEmpty;
        busy = state != IDLE;
`ifdef UART_TX_PARITY_EN
        txd_next = state_next == START  ? 1'b0 :
                   state_next == DATA   ? shift_next[0] :
                   state_next == PARITY ? parity : 1'b1;
`else
        txd_next = state_next == START ? 1'b0 :
                   state_next == DATA  ? shift_next[0] : 1'b1;
`endif
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random FIFO traffic against a per-cycle line model of the transmitter
module tb_uart_tx;

    localparam int CD = 4;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + SB - 1 + PAR) * CD;
    localparam int NB    = 10 + PAR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] fByte = 8'h00;
    logic       fEmpty = 1'b1;
    logic       fPop, txd, busy;

    logic [7:0] fifo[$];
    logic [7:0] mq[$];
    bit         q[$];
    logic       pop_seen = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         pops = 0;

    uart_tx #(.ClockDivider(CD), .StopBits(SB)) dut (
        .clock (clk),
        .reset (reset),
        .fByte (fByte),
        .fEmpty(fEmpty),
        .fPop  (fPop),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // FIFO side: registered output valid the cycle after a pop, junk otherwise
    always @(posedge clk) begin
        #1;
        if (pop_seen && fifo.size() != 0)
            fByte = fifo.pop_front();
        else
            fByte = 8'($urandom);
        fEmpty = fifo.size() == 0;
    end

    // model: expected line level per cycle is a queue of bits, empty means idle
    always @(negedge clk) begin
        bit         exp_txd, exp_busy, exp_pop;
        logic [7:0] b;
        if (!reset)
            q.delete();
        exp_txd  = q.size() != 0 ? q[0] : 1'b1;
        exp_busy = q.size() != 0;
        exp_pop  = reset && q.size() == 0 && !fEmpty;
        check("txd", txd, exp_txd);
        check("busy", busy, exp_busy);
        check("fPop", fPop, exp_pop);
        pop_seen = fPop;
        if (reset) begin
            if (q.size() != 0)
                void'(q.pop_front());
            if (exp_pop) begin
                pops++;
                b = mq.size() != 0 ? mq.pop_front() : 8'h00;
                q.push_back(1'b1);
                repeat (CD) q.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    repeat (CD) q.push_back(b[i]);
                if (PAR != 0)
                    repeat (CD) q.push_back(^b);
                repeat (SB * CD) q.push_back(1'b1);
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #2;
        fifo.push_back(b);
        mq.push_back(b);
    endtask

    task automatic wait_pop(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fPop && n < 3000);
        if (!fPop)
            check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !fEmpty) && n < 5000);
        if (busy || !fEmpty)
            check("idle_timeout", 0, 1);
    endtask

    // called on the negedge of the pop cycle; samples mid-bit against a literal frame
    task automatic frame_check(input string name, input logic [10:0] bits);
        for (int k = 0; k < NB; k++) begin
            repeat (k == 0 ? 3 : CD) @(negedge clk);
            check(name, txd, bits[k]);
        end
    endtask

    task automatic reset_pulse(input int cyc);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_txd_now", txd, 1);
        check("rst_pop_now", fPop, 0);
        repeat (cyc) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int saved, n;
        #1 reset = 1'b0;
        fifo.push_back(8'hA5);
        mq.push_back(8'hA5);
        repeat (20) @(negedge clk);
        check("rst_fpop", fPop, 0);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("release_pop", fPop, 1);
`ifdef UART_TX_PARITY_EN
        frame_check("a5_frame", 11'b101_0100_1010);
`else
        frame_check("a5_frame", 11'b011_0100_1010);
`endif
        wait_idle();
        @(posedge clk);
        check("single_pops", pops, 1);

        push(8'h00);
        fifo.push_back(8'hFF);
        mq.push_back(8'hFF);
        wait_pop("b2b_first");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fPop && n < 200);
        check("b2b_gap", n, FRAME + 2);
        wait_idle();

        @(posedge clk);
        saved = pops;
        repeat (1000) @(negedge clk);
        @(posedge clk);
        check("empty_pops", pops, saved);

        push(8'h3C);
        wait_pop("mid_pop");
        repeat (19) @(negedge clk);
        @(posedge clk);
        saved = pops;
        reset_pulse(3);
        push(8'h5A);
        wait_pop("after_rst_pop");
`ifdef UART_TX_PARITY_EN
        frame_check("5a_frame", 11'b100_1011_0100);
`else
        frame_check("5a_frame", 11'b010_1011_0100);
`endif
        wait_idle();
        @(posedge clk);
        check("after_rst_pops", pops, saved + 1);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        fifo.push_back(8'h03);
        mq.push_back(8'h03);
        wait_pop("par07_pop");
        frame_check("par07_frame", 11'b110_0000_1110);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fPop && n < 200);
        check("par_gap", 3 + CD * (NB - 1) + n, 46);
        frame_check("par03_frame", 11'b100_0000_0110);
        wait_idle();
`endif

        for (int i = 0; i < 40; i++) begin
            push(8'($urandom));
            if ($urandom_range(0, 9) == 0)
                reset_pulse($urandom_range(1, 3));
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("drain_model", mq.size(), 0);
        check("drain_fifo", fifo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
